// File: rtl/hex_event_reader_fsm_if.sv
// Bundles the buffer read port, the event output stream and the frame control/status
// of the hex event reader. master = the reader, slave = buffer/consumer/controller side.
interface hex_event_reader_fsm_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 256
);
   localparam int AW = $clog2(DEPTH);

   logic              start;
   logic [31:0]       event_count;
   logic              rd_en;
   logic [AW-1:0]     rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              valid_out;
   logic              ready_in;
   logic signed [15:0] q;
   logic signed [15:0] r;
   logic [7:0]        depth_val;
   logic [7:0]        material;
   logic              last;
   logic              busy;
   logic              done;
   logic [31:0]       read_count;
   logic              count_clamped;
   logic              pad_error;

   modport master (
      input  start, event_count, rd_data, ready_in,
      output rd_en, rd_addr, valid_out, q, r, depth_val, material,
             last, busy, done, read_count, count_clamped, pad_error
   );

   modport slave (
      output start, event_count, rd_data, ready_in,
      input  rd_en, rd_addr, valid_out, q, r, depth_val, material,
             last, busy, done, read_count, count_clamped, pad_error
   );
endinterface

// File: rtl/hex_event_reader_fsm.sv
// Drains entries 0..N-1 of the frame event buffer through a 3-entry prefetch FIFO and
// presents unpacked hex events on a valid/ready stream.
module hex_event_reader_fsm #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 256
) (
   input logic                    clk,
   input logic                    reset,
   hex_event_reader_fsm_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t           state_reg, state_next;
   logic [31:0]      total_reg;
   logic [31:0]      issued_reg;
   logic             inflight_reg;
   logic [1:0]       wr_ptr_reg, rd_ptr_reg, occ_reg;
   logic [WIDTH-1:0] fifo_mem [3];
   logic [31:0]      read_count_reg;
   logic             clamped_reg, pad_reg;

   logic             start_accept, clamp, issue, push, pop, valid, head_last;
   logic [31:0]      total_in;
   logic [WIDTH-1:0] head;

   function automatic logic [1:0] bump(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign start_accept = (state_reg == IDLE) && bus.start;
   assign clamp        = bus.event_count > 32'(DEPTH);
   assign total_in     = clamp ? 32'(DEPTH) : bus.event_count;

   // Issue depends only on registered state: FIFO occupancy plus the one read in flight.
   assign issue = (state_reg == RUN) && (issued_reg < total_reg) &&
                  (({1'b0, occ_reg} + {2'b00, inflight_reg}) < 3'd3);
   assign push      = inflight_reg;
   assign valid     = (occ_reg != 2'd0);
   assign pop       = valid && bus.ready_in;
   assign head      = fifo_mem[rd_ptr_reg];
   assign head_last = valid && (read_count_reg == total_reg - 32'd1);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = (total_in == 32'd0) ? DONE : RUN;
         RUN: begin
            if (pop && head_last)            state_next = DONE;
            else if (issued_reg == total_reg) state_next = FLUSH;
         end
         FLUSH:   if (pop && head_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         total_reg      <= '0;
         issued_reg     <= '0;
         inflight_reg   <= 1'b0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         occ_reg        <= '0;
         read_count_reg <= '0;
         clamped_reg    <= 1'b0;
         pad_reg        <= 1'b0;
      end else begin
         state_reg    <= state_next;
         inflight_reg <= issue;
         if (start_accept) begin
            total_reg      <= total_in;
            clamped_reg    <= clamp;
            issued_reg     <= '0;
            read_count_reg <= '0;
            pad_reg        <= 1'b0;
         end else begin
            if (issue) issued_reg <= issued_reg + 32'd1;
            if (pop) begin
               read_count_reg <= read_count_reg + 32'd1;
               if (head[15:0] != 16'd0) pad_reg <= 1'b1;
            end
         end
         if (push) wr_ptr_reg <= bump(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= bump(rd_ptr_reg);
         occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage is cleared on reset so the unpacked fields idle at zero.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
         always_ff @(posedge clk) begin
            if (reset)
               fifo_mem[gi] <= '0;
            else if (push && (wr_ptr_reg == 2'(gi)))
               fifo_mem[gi] <= bus.rd_data;
         end
      end
   endgenerate

   assign bus.rd_en         = issue;
   assign bus.rd_addr       = issued_reg[AW-1:0];
   assign bus.valid_out     = valid;
   assign bus.q             = head[63:48];
   assign bus.r             = head[47:32];
   assign bus.depth_val     = head[31:24];
   assign bus.material      = head[23:16];
   assign bus.last          = head_last;
   assign bus.busy          = (state_reg == RUN) || (state_reg == FLUSH);
   assign bus.done          = (state_reg == DONE);
   assign bus.read_count    = read_count_reg;
   assign bus.count_clamped = clamped_reg;
   assign bus.pad_error     = pad_reg;
endmodule

// File: tb/tb_hex_event_reader_fsm.sv
// Directed bench for hex_event_reader_fsm: buffer model, expected-event scoreboard queue,
// and a stream monitor that checks order, fields, last, stalls and outstanding reads.
module tb_hex_event_reader_fsm;
   localparam int WIDTH = 64;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hex_event_reader_fsm_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   hex_event_reader_fsm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [63:0] mem [DEPTH];
   logic [63:0] exp_q [$];
   int total_cnt = 0;
   int bad_cnt   = 0;
   int issue_cnt = 0;
   int hs_cnt    = 0;
   logic        stall_prev = 1'b0;
   logic [47:0] held;

   // Synchronous read port of the event buffer.
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total_cnt++;
      assert (obs === expv) else begin
         bad_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] mk(input int k, input logic [15:0] pad);
      logic [15:0] qq;
      logic [15:0] rr;
      qq = 16'(k);
      rr = 16'(-k);
      return {qq, rr, 8'(10 + k), 8'(k), pad};
   endfunction

   // Stream monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         issue_cnt  = 0;
         hs_cnt     = 0;
         stall_prev = 1'b0;
      end else begin
         if (bus.start && !bus.busy) begin
            issue_cnt = 0;
            hs_cnt    = 0;
         end
         if (bus.rd_en) begin
            chk("rd_addr", 64'(bus.rd_addr), 64'(issue_cnt));
            chk("outstanding_lt3", 64'(issue_cnt - hs_cnt < 3), 64'd1);
            issue_cnt++;
         end
         if (stall_prev) begin
            chk("stall_valid", 64'(bus.valid_out), 64'd1);
            chk("stall_fields", 64'({bus.q, bus.r, bus.depth_val, bus.material}), 64'(held));
         end
         stall_prev = bus.valid_out && !bus.ready_in;
         held       = {bus.q, bus.r, bus.depth_val, bus.material};
         if (bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", 64'(hs_cnt), 64'hFFFF_FFFF);
            end else begin
               logic [63:0] w;
               w = exp_q.pop_front();
               $display("event %0d q=%0d r=%0d depth=%0d material=%0d last=%0b",
                        hs_cnt, bus.q, bus.r, bus.depth_val, bus.material, bus.last);
               chk("fields", 64'({bus.q, bus.r, bus.depth_val, bus.material}), 64'(w[63:16]));
               chk("last", 64'(bus.last), 64'(exp_q.size() == 0));
            end
            hs_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input int pad_idx);
      for (int k = 0; k < n; k++) mem[k] = mk(k, (k == pad_idx) ? 16'h0001 : 16'h0000);
   endtask

   // Drives start in cycle 0 and returns one tick later (cycle 1).
   task automatic frame(input int count, input int n_exp);
      exp_q.delete();
      for (int k = 0; k < n_exp; k++) exp_q.push_back(mem[k]);
      bus.event_count = 32'(count);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && bus.done !== 1'b1; i++) tick();
      chk("done_seen", 64'(bus.done), 64'd1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", 64'(bus.valid_out), 64'd0);
      chk("rst_last", 64'(bus.last), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
      chk("rst_flags", 64'({bus.count_clamped, bus.pad_error}), 64'd0);
      chk("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
      chk("rst_fields", 64'({bus.q, bus.r, bus.depth_val, bus.material}), 64'd0);
      chk("rst_read_count", 64'(bus.read_count), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 1'b0;
      bus.event_count = '0;
      bus.ready_in = 1'b0;
      tick();
      tick();
      chk_reset_vals();
      reset = 1'b0;
      tick();

      // Five events, consumer always ready.
      load(5, -1);
      bus.ready_in = 1'b1;
      frame(5, 5);
      chk("t1_busy_c1", 64'(bus.busy), 64'd1);
      chk("t1_rd_en_c1", 64'(bus.rd_en), 64'd1);
      chk("t1_addr_c1", 64'(bus.rd_addr), 64'd0);
      tick();
      chk("t1_valid_c2", 64'(bus.valid_out), 64'd0);
      tick();
      for (int c = 3; c <= 7; c++) begin
         chk("t1_valid", 64'(bus.valid_out), 64'd1);
         chk("t1_last_cycle", 64'(bus.last), 64'(c == 7));
         chk("t1_done_early", 64'(bus.done), 64'd0);
         tick();
      end
      chk("t1_done_c8", 64'(bus.done), 64'd1);
      chk("t1_busy_c8", 64'(bus.busy), 64'd0);
      chk("t1_read_count", 64'(bus.read_count), 64'd5);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();
      chk("t1_done_pulse", 64'(bus.done), 64'd0);
      chk("t1_read_count_hold", 64'(bus.read_count), 64'd5);

      // Empty frame.
      frame(0, 0);
      chk("t2_done_c1", 64'(bus.done), 64'd1);
      for (int c = 1; c <= 3; c++) begin
         chk("t2_quiet", 64'({bus.busy, bus.rd_en, bus.valid_out}), 64'd0);
         tick();
      end
      chk("t2_done_pulse", 64'(bus.done), 64'd0);

      // Clamped frame: 300 requested, 256 delivered.
      load(DEPTH, -1);
      frame(300, DEPTH);
      chk("t3_clamped", 64'(bus.count_clamped), 64'd1);
      wait_done(400);
      chk("t3_read_count", 64'(bus.read_count), 64'd256);
      chk("t3_issued", 64'(issue_cnt), 64'd256);
      chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      // Eight events under random backpressure with a 10-cycle stall.
      load(8, -1);
      frame(8, 8);
      chk("t4_unclamped", 64'(bus.count_clamped), 64'd0);
      for (int i = 0; i < 300 && bus.done !== 1'b1; i++) begin
         bus.ready_in = (i >= 3 && i < 13) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
      end
      chk("t4_done_seen", 64'(bus.done), 64'd1);
      chk("t4_read_count", 64'(bus.read_count), 64'd8);
      chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      bus.ready_in = 1'b1;
      tick();

      // Entry 2 carries nonzero padding.
      load(5, 2);
      frame(5, 5);
      chk("t5_pad_c1", 64'(bus.pad_error), 64'd0);
      for (int c = 1; c < 5; c++) tick();
      chk("t5_pad_c5", 64'(bus.pad_error), 64'd0);
      tick();
      chk("t5_pad_c6", 64'(bus.pad_error), 64'd1);
      wait_done(20);
      chk("t5_pad_sticky", 64'(bus.pad_error), 64'd1);
      tick();

      // Reset in cycle 5 of a 20-event frame, then a clean 3-event frame.
      load(20, -1);
      frame(20, 20);
      chk("t6_pad_cleared", 64'(bus.pad_error), 64'd0);
      for (int c = 1; c < 5; c++) tick();
      reset = 1'b1;
      tick();
      chk_reset_vals();
      reset = 1'b0;
      exp_q.delete();
      tick();
      chk("t6_no_stale_push", 64'({bus.valid_out, bus.busy, bus.done}), 64'd0);
      load(3, -1);
      frame(3, 3);
      wait_done(20);
      chk("t6_read_count", 64'(bus.read_count), 64'd3);
      chk("t6_issued", 64'(issue_cnt), 64'd3);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule

// File: doc/hex_event_reader_fsm.md
# hex_event_reader_fsm

Drain side of the per-frame hex event buffer. When the frame's event list is complete, this block reads entries `0 .. N-1` from the buffer's synchronous read port. It unpacks each 64-bit event word into axial coordinates, depth and material, and presents them to the downstream hex resolver on a valid/ready stream. Backpressure never drops or reorders events. A small prefetch FIFO sustains one event per cycle when the consumer is always ready.

## Interface
- `WIDTH`, 64, event word width; must be 64, other values unsupported
- `DEPTH`, 256, buffer entries; read address width is `$clog2(DEPTH)`
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  in  1  one-cycle pulse: begin draining a frame; ignored while `busy`
- `event_count`  in  32  number of valid entries, sampled on `start`
- `rd_en`  out  1  buffer read request
- `rd_addr`  out  `$clog2(DEPTH)`  buffer read address
- `rd_data`  in  `WIDTH`  buffer data, valid the cycle after `rd_en`
- `valid_out`  out  1  event presented
- `ready_in`  in  1  consumer accepts; handshake = `valid_out & ready_in`
- `q`, `r`  out  16 each, signed  axial coordinates, `rd_data[63:48]`, `[47:32]`
- `depth_val`  out  8  `rd_data[31:24]`
- `material`  out  8  `rd_data[23:16]`
- `last`  out  1  high with the final event of the frame
- `busy`  out  1  frame drain in progress
- `done`  out  1  one-cycle pulse, frame fully drained
- `read_count`  out  32  handshakes completed this frame
- `count_clamped`  out  1  sticky per frame: `event_count > DEPTH`
- `pad_error`  out  1  sticky per frame: any accepted word had nonzero `[15:0]`

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: issues reads and drains.
  - FLUSH: all reads issued; waits for the FIFO and in-flight data to empty.
  - DONE: one cycle, asserts `done`, then returns to IDLE.
- On `start` in IDLE:
  - `total = min(event_count, DEPTH)`; `count_clamped` = (`event_count > DEPTH`).
  - Clear `read_count`, `pad_error`, issue pointer.
  - Go to RUN. If `total == 0`, go directly to DONE.
- Issue rule, evaluated every cycle in RUN: `rd_en = (issued < total) && (fifo_occ + inflight < 3)`.
  - `rd_addr = issued`, which increments per issue.
  - Depends only on registered state, with no combinational path from `ready_in`.
- Read data returns the cycle after `rd_en` and is pushed into a 3-entry FIFO. The FIFO can never overflow by construction.
- The FIFO head drives `valid_out` and the unpacked fields. Fields hold stable while `valid_out & !ready_in`.
- `last` = head is entry `total-1`.
- Each handshake: pop the head and increment `read_count`. Set `pad_error` if the accepted word had `[15:0] != 0`.
- RUN→FLUSH when `issued == total`. FLUSH→DONE on the handshake of the final entry.
- `busy` is high in RUN and FLUSH.
- `start` while busy: ignored, with no effect on counters.
- `reset` mid-frame: state returns to IDLE immediately, FIFO is emptied, in-flight data is discarded, and no `done` is issued.

## Timing
- Reset values: `valid_out`, `last`, `busy`, `done`, `rd_en`, `count_clamped`, `pad_error` = 0; `rd_addr`, `q`, `r`, `depth_val`, `material`, `read_count` = 0.
- With `start` in cycle 0 and `total = N ≥ 1`:
  - `busy` and `rd_en` (addr 0) in cycle 1.
  - `rd_data` in cycle 2.
  - `valid_out` with entry 0 in cycle 3.
- With `ready_in` held high: entry k appears in cycle 3+k, `last` in cycle N+2, `done` in cycle N+3, `busy` low from cycle N+3.
- `total == 0`: `done` in cycle 1, `busy` never asserted, no `rd_en`.
- `ready_in` low stalls issue after at most 3 outstanding entries (FIFO plus in-flight). Issue resumes the cycle after the first pop frees a slot.
- `read_count` updates the cycle after each handshake and holds its final value until the next `start`.

## Test plan
- Buffer preloaded with 5 words {q=k, r=-k, depth=10+k, material=k}, `event_count=5`, `ready_in=1` -> entries 0..4 in cycles 3..7 with matching fields, `last` only in cycle 7, `done` in cycle 8, `read_count=5`.
- `event_count=0` -> `done` in cycle 1; `rd_en`, `valid_out`, `busy` never assert.
- `event_count=300`, `DEPTH=256` -> `count_clamped=1`; exactly 256 events, addresses 0..255, no wrap; `read_count=256`.
- `event_count=8`, `ready_in` toggling 1/0 randomly plus a 10-cycle low stretch -> in-order delivery, fields stable while stalled, never more than 3 outstanding reads, all 8 delivered.
- Entry 2 padded with `16'h0001` -> `pad_error` rises after entry 2's handshake and clears on the next `start`.
- `reset` asserted in cycle 5 of a 20-event frame -> all outputs at reset values next cycle. A subsequent `start` with `event_count=3` delivers entries 0..2 cleanly.
